// File: rtl/cpu_run_ctrl_pkg.sv
// rtl/cpu_run_ctrl_pkg.sv - shared state and termination-reason encodings for the run controller
package cpu_run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    HALT    = 2'd1,
    BREAK   = 2'd2,
    TIMEOUT = 2'd3
  } reason_t;

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// rtl/cpu_run_ctrl_sat_counter.sv - clearable up-counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != '1)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - sequences cpu reset, times a run, ends it on halt/breakpoint/watchdog
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_halt,
  input  logic              i_mem_wen,
  input  logic [ADDR_W-1:0] i_mem_address,
  input  logic [DATA_W-1:0] i_mem_data_in,
  input  logic              i_break_en,
  input  logic [ADDR_W-1:0] i_break_addr,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_reason,
  output logic [CNT_W-1:0]  o_cycle_count,
  output logic [CNT_W-1:0]  o_wr_count,
  output logic [ADDR_W-1:0] o_last_wr_addr,
  output logic [DATA_W-1:0] o_last_wr_data
);

  localparam int                RC_W        = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0]   LP_RST_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LP_WD_LAST  = CNT_W'(MAX_CYCLES - 1);

  state_t              r_state;
  state_t              w_next_state;
  reason_t             r_reason;
  reason_t             w_term_reason;
  logic [RC_W-1:0]     r_rst_cnt;
  logic                r_cpu_rst;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W-1:0]   r_last_wr_addr;
  logic [DATA_W-1:0]   r_last_wr_data;
  logic [CNT_W-1:0]    w_cycle_count;
  logic [CNT_W-1:0]    w_wr_count;
  logic                w_start_acc;
  logic                w_run;
  logic                w_wr;
  logic                w_brk;
  logic                w_tmo;

  assign w_run = (r_state == RUN);
  assign w_wr  = w_run && i_mem_wen;
  assign w_brk = i_break_en && i_mem_wen && (i_mem_address == i_break_addr);
  // Compared before the increment so the terminating cycle lands on exactly MAX_CYCLES.
  assign w_tmo = (MAX_CYCLES != 0) && (w_cycle_count == LP_WD_LAST);

  always_comb begin
    w_next_state  = r_state;
    w_term_reason = NONE;
    w_start_acc   = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_next_state = RESET;
          w_start_acc  = 1'b1;
        end
      end
      RESET: begin
        if (r_rst_cnt == LP_RST_LAST) begin
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (i_halt) begin
          w_term_reason = HALT;
        end else if (w_brk) begin
          w_term_reason = BREAK;
        end else if (w_tmo) begin
          w_term_reason = TIMEOUT;
        end
        if (w_term_reason != NONE) begin
          w_next_state = DONE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state        <= IDLE;
      r_reason       <= NONE;
      r_rst_cnt      <= '0;
      r_cpu_rst      <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_last_wr_addr <= '0;
      r_last_wr_data <= '0;
    end else begin
      r_state   <= w_next_state;
      // Status flags are decoded from the next state so they change together with it.
      r_cpu_rst <= (w_next_state != RUN);
      r_busy    <= (w_next_state == RESET) || (w_next_state == RUN);
      r_done    <= (w_next_state == DONE);
      r_rst_cnt <= (r_state == RESET) ? r_rst_cnt + RC_W'(1) : '0;
      if (w_start_acc) begin
        r_reason <= NONE;
      end else if (w_run && (w_term_reason != NONE)) begin
        r_reason <= w_term_reason;
      end
      if (w_start_acc) begin
        r_last_wr_addr <= '0;
        r_last_wr_data <= '0;
      end else if (w_wr) begin
        r_last_wr_addr <= i_mem_address;
        r_last_wr_data <= i_mem_data_in;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_start_acc),
    .i_inc (w_run),
    .o_q   (w_cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_start_acc),
    .i_inc (w_wr),
    .o_q   (w_wr_count)
  );

  assign o_cpu_rst      = r_cpu_rst;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_reason       = r_reason;
  assign o_cycle_count  = w_cycle_count;
  assign o_wr_count     = w_wr_count;
  assign o_last_wr_addr = r_last_wr_addr;
  assign o_last_wr_data = r_last_wr_data;

endmodule
